// File: rtl/cam_pkg.sv
// Shared encodings for the camera capture path: pixel format codes, FSM states and a few
// RGB332 reference colours.
package cam_pkg;

  localparam logic [1:0] FMT_RGB565   = 2'd0;
  localparam logic [1:0] FMT_444_MSB2 = 2'd1;
  localparam logic [1:0] FMT_444_MSB1 = 2'd2;
  localparam logic [1:0] FMT_GREY     = 2'd3;

  typedef enum logic [0:0] {
    StWaitFrame = 1'b0,
    StActive    = 1'b1
  } cam_state_e;

  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;
  localparam logic [7:0] WHITE = 8'hFF;

endpackage

// File: rtl/sync_edge_filt.sv
// Qualified edge detector: SYNC_FILT stable samples after an opposite-level sample give one
// pulse. RISE selects rising (1) or falling (0) edges.
module sync_edge_filt #(
  parameter int unsigned SYNC_FILT = 2,
  parameter bit          RISE      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  // Bit 0 is the newest sample, bit SYNC_FILT the oldest.
  logic [SYNC_FILT:0] hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[SYNC_FILT-1:0], d_i};
    end
  end

  if (RISE) begin : g_rise
    assign pulse_o = (&hist_q[SYNC_FILT-1:0]) & ~hist_q[SYNC_FILT];
  end else begin : g_fall
    assign pulse_o = ~(|hist_q[SYNC_FILT-1:0]) & hist_q[SYNC_FILT];
  end

endmodule

// File: rtl/cam_capture_ds.sv
// OV7670 capture front end: filtered sync edges, byte-pair assembly, RGB332 conversion and
// framebuffer write port. Define CAM_DECIM2_EN for 2x decimation in both axes.
module cam_capture_ds
  import cam_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 176,
  parameter int unsigned SCREEN_HEIGHT = 144,
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned SYNC_FILT     = 2,
  parameter int unsigned LINE_W        = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        FORMAT,
  input  logic              CAPTURE_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic [LINE_W-1:0] LINE_COUNT,
  output logic              CLIP_ERR
);

  localparam int unsigned XW = $clog2(SCREEN_WIDTH + 1);
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0]     X_MAX     = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]     Y_MAX     = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

  logic              vs_rise, hr_fall;
  logic              href_q;
  logic [7:0]        data_q, b0_q;
  cam_state_e        state_q;
  logic [1:0]        fmt_q;
  logic              cap_en_q, phase_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] base_q;
  logic [LINE_W-1:0] line_cnt_q;
  logic              clip_q, w_en_q, frame_done_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [7:0]        w_data_q;
  logic [15:0]       pix_word;
  logic [7:0]        pix;
  logic              in_frame, keep;
  logic              unused_word;

  sync_edge_filt #(
    .SYNC_FILT (SYNC_FILT),
    .RISE      (1'b1)
  ) u_vs_filt (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .d_i     (VSYNC),
    .pulse_o (vs_rise)
  );

  sync_edge_filt #(
    .SYNC_FILT (SYNC_FILT),
    .RISE      (1'b0)
  ) u_hr_filt (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .d_i     (HREF),
    .pulse_o (hr_fall)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      href_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      href_q <= HREF;
      data_q <= CAM_DATA;
    end
  end

  assign pix_word    = {data_q, b0_q};
  assign unused_word = ^{pix_word[8], pix_word[4]};

  always_comb begin
    pix = 8'h00;
    unique case (fmt_q)
      FMT_RGB565:   pix = {pix_word[7:5], pix_word[2:0], pix_word[12:11]};
      FMT_444_MSB2: pix = {pix_word[11:9], pix_word[7:5], pix_word[3:2]};
      FMT_444_MSB1: pix = {pix_word[3:1], pix_word[15:13], pix_word[11:10]};
      FMT_GREY:     pix = {pix_word[7:5], pix_word[7:5], pix_word[7:6]};
      default:      pix = 8'h00;
    endcase
  end

  assign in_frame = (x_q < X_MAX) && (y_q < Y_MAX);

`ifdef CAM_DECIM2_EN
  // Parity of the camera column and line currently being received.
  logic col_odd_q, line_odd_q;
  assign keep = ~col_odd_q & ~line_odd_q;
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StWaitFrame;
      fmt_q        <= FMT_RGB565;
      cap_en_q     <= 1'b0;
      phase_q      <= 1'b0;
      b0_q         <= 8'h00;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      line_cnt_q   <= '0;
      clip_q       <= 1'b0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= 8'h00;
      frame_done_q <= 1'b0;
`ifdef CAM_DECIM2_EN
      col_odd_q    <= 1'b0;
      line_odd_q   <= 1'b0;
`endif
    end else begin
      w_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      // A frame start overrides a coincident line end.
      if (vs_rise) begin
        state_q      <= StActive;
        frame_done_q <= (state_q == StActive) && (line_cnt_q != '0);
        fmt_q        <= FORMAT;
        cap_en_q     <= CAPTURE_EN;
        phase_q      <= 1'b0;
        x_q          <= '0;
        y_q          <= '0;
        base_q       <= '0;
        line_cnt_q   <= '0;
`ifdef CAM_DECIM2_EN
        col_odd_q    <= 1'b0;
        line_odd_q   <= 1'b0;
`endif
      end else if (state_q == StActive) begin
        if (hr_fall) begin
          if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + 1'b1;
          x_q     <= '0;
          phase_q <= 1'b0;
`ifdef CAM_DECIM2_EN
          col_odd_q  <= 1'b0;
          line_odd_q <= ~line_odd_q;
          if (!line_odd_q && (y_q < Y_MAX)) begin
`else
          if (y_q < Y_MAX) begin
`endif
            y_q    <= y_q + 1'b1;
            base_q <= base_q + LINE_STEP;
          end
        end else if (href_q) begin
          if (!phase_q) begin
            b0_q    <= data_q;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
`ifdef CAM_DECIM2_EN
            col_odd_q <= ~col_odd_q;
`endif
            if (keep) begin
              if (in_frame) begin
                w_en_q   <= cap_en_q;
                w_addr_q <= base_q + ADDR_W'(x_q);
                w_data_q <= pix;
              end else begin
                clip_q <= 1'b1;
              end
              if (x_q < X_MAX) x_q <= x_q + 1'b1;
            end
          end
        end else begin
          // Odd byte count: the dangling first byte is dropped.
          phase_q <= 1'b0;
        end
      end
    end
  end

  assign W_EN       = w_en_q;
  assign W_ADDR     = w_addr_q;
  assign W_DATA     = w_data_q;
  assign FRAME_DONE = frame_done_q;
  assign LINE_COUNT = line_cnt_q;
  assign CLIP_ERR   = clip_q;

endmodule

// File: tb/tb_cam_capture_ds.sv
// Directed bench for cam_capture_ds (default build, CAM_DECIM2_EN undefined).
module tb_cam_capture_ds;

  localparam int unsigned AW = 15;
  localparam int unsigned LW = 9;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          VSYNC;
  logic          HREF;
  logic [7:0]    CAM_DATA;
  logic [1:0]    FORMAT;
  logic          CAPTURE_EN;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          W_EN;
  logic          FRAME_DONE;
  logic [LW-1:0] LINE_COUNT;
  logic          CLIP_ERR;

  always #5 CLK = ~CLK;

  cam_capture_ds #(
    .SCREEN_WIDTH  (176),
    .SCREEN_HEIGHT (144),
    .ADDR_W        (AW),
    .SYNC_FILT     (2),
    .LINE_W        (LW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .CAM_DATA   (CAM_DATA),
    .FORMAT     (FORMAT),
    .CAPTURE_EN (CAPTURE_EN),
    .W_ADDR     (W_ADDR),
    .W_DATA     (W_DATA),
    .W_EN       (W_EN),
    .FRAME_DONE (FRAME_DONE),
    .LINE_COUNT (LINE_COUNT),
    .CLIP_ERR   (CLIP_ERR)
  );

  int n_vec = 0;
  int n_err = 0;

  // Write monitor: every strobe is logged so segments can be inspected afterwards.
  int            wr_cnt = 0;
  int            fd_cnt = 0;
  logic [AW-1:0] log_addr [4096];
  logic [7:0]    log_data [4096];

  always @(negedge CLK) begin
    if (W_EN) begin
      if (wr_cnt < 4096) begin
        log_addr[wr_cnt] <= W_ADDR;
        log_data[wr_cnt] <= W_DATA;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic vsync_pulse(input int n);
    VSYNC = 1'b1;
    HREF  = 1'b0;
    repeat (n) @(negedge CLK);
    VSYNC = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1);
    HREF = 1'b1;
    for (int i = 0; i < n; i++) begin
      CAM_DATA = i[0] ? b1 : b0;
      @(negedge CLK);
    end
    HREF = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1);
    send_bytes(2 * npix, b0, b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int fd0;

    RESET      = 1'b1;
    VSYNC      = 1'b0;
    HREF       = 1'b0;
    CAM_DATA   = 8'h00;
    FORMAT     = 2'd0;
    CAPTURE_EN = 1'b1;
    repeat (3) @(negedge CLK);
    check_eq("rst_w_en", W_EN, 0);
    check_eq("rst_w_addr", W_ADDR, 0);
    check_eq("rst_w_data", W_DATA, 0);
    check_eq("rst_frame_done", FRAME_DONE, 0);
    check_eq("rst_line_count", LINE_COUNT, 0);
    check_eq("rst_clip", CLIP_ERR, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Data before any frame start is ignored.
    base = wr_cnt;
    send_line(2, 8'hF8, 8'h1F);
    check_eq("preframe_writes", wr_cnt - base, 0);
    check_eq("preframe_lines", LINE_COUNT, 0);

    // Frame A: two full RGB565 lines.
    vsync_pulse(4);
    check_eq("first_vs_no_done", fd_cnt, 0);
    base = wr_cnt;
    send_line(176, 8'hF8, 8'h1F);
    send_line(176, 8'hF8, 8'h1F);
    check_eq("a_writes", wr_cnt - base, 352);
    check_eq("a_first_addr", log_addr[base], 0);
    check_eq("a_first_data", log_data[base], 8'hE3);
    check_eq("a_last_addr", log_addr[wr_cnt-1], 351);
    check_eq("a_lines", LINE_COUNT, 2);
    check_eq("a_clip", CLIP_ERR, 0);

    // Frame B: RGB444 MSB-second; FORMAT change mid-frame is ignored.
    FORMAT = 2'd1;
    fd0 = fd_cnt;
    vsync_pulse(4);
    check_eq("b_frame_done", fd_cnt - fd0, 1);
    check_eq("b_lines_cleared", LINE_COUNT, 0);
    base = wr_cnt;
    send_line(1, 8'h5A, 8'h0F);
    FORMAT = 2'd2;
    send_line(1, 8'h5A, 8'h0F);
    check_eq("b_writes", wr_cnt - base, 2);
    check_eq("b_data0", log_data[base], 8'hEA);
    check_eq("b_addr0", log_addr[base], 0);
    check_eq("b_data1_fmt_held", log_data[base+1], 8'hEA);
    check_eq("b_addr1", log_addr[base+1], 176);

    // Frame C: RGB444 MSB-first, then an odd-length line.
    vsync_pulse(4);
    base = wr_cnt;
    send_line(1, 8'h5A, 8'h0F);
    check_eq("c_data_msb1", log_data[base], 8'hA3);
    check_eq("c_addr0", log_addr[base], 0);
    base = wr_cnt;
    send_bytes(7, 8'h5A, 8'h0F);
    check_eq("c_odd_writes", wr_cnt - base, 3);
    check_eq("c_odd_first", log_addr[base], 176);
    check_eq("c_odd_last", log_addr[wr_cnt-1], 178);
    base = wr_cnt;
    send_line(1, 8'h5A, 8'h0F);
    check_eq("c_next_line_addr", log_addr[base], 352);
    check_eq("c_lines", LINE_COUNT, 3);

    // Frame D: grey, over-long first line, then past the last stored line.
    FORMAT = 2'd3;
    vsync_pulse(4);
    base = wr_cnt;
    send_line(180, 8'h5A, 8'h0F);
    check_eq("d_long_writes", wr_cnt - base, 176);
    check_eq("d_long_last_addr", log_addr[wr_cnt-1], 175);
    check_eq("d_grey_data", log_data[wr_cnt-1], 8'h49);
    check_eq("d_clip_set", CLIP_ERR, 1);
    for (int k = 1; k < 144; k++) send_line(1, 8'h5A, 8'h0F);
    check_eq("d_frame_writes", wr_cnt - base, 319);
    check_eq("d_last_line_addr", log_addr[wr_cnt-1], 25168);
    check_eq("d_lines_144", LINE_COUNT, 144);
    base = wr_cnt;
    send_line(1, 8'h5A, 8'h0F);
    check_eq("d_line145_writes", wr_cnt - base, 0);
    check_eq("d_lines_145", LINE_COUNT, 145);

    // One-cycle VSYNC glitch must not restart the frame.
    fd0 = fd_cnt;
    vsync_pulse(1);
    check_eq("glitch_lines", LINE_COUNT, 145);
    check_eq("glitch_no_done", fd_cnt - fd0, 0);

    // Sustained VSYNC: single FRAME_DONE, frame E restarts at address 0.
    FORMAT = 2'd0;
    vsync_pulse(8);
    check_eq("e_frame_done", fd_cnt - fd0, 1);
    check_eq("e_lines_cleared", LINE_COUNT, 0);
    check_eq("e_clip_sticky", CLIP_ERR, 1);
    base = wr_cnt;
    send_line(1, 8'hF8, 8'h1F);
    check_eq("e_first_addr", log_addr[base], 0);
    check_eq("e_first_data", log_data[base], 8'hE3);

    // Frame F: capture disabled at frame start, enabled mid-frame.
    CAPTURE_EN = 1'b0;
    vsync_pulse(4);
    CAPTURE_EN = 1'b1;
    base = wr_cnt;
    send_line(2, 8'hF8, 8'h1F);
    check_eq("f_lines", LINE_COUNT, 1);
    // Line end coincides with frame start.
    fd0 = fd_cnt;
    HREF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      CAM_DATA = i[0] ? 8'h1F : 8'hF8;
      @(negedge CLK);
    end
    HREF  = 1'b0;
    VSYNC = 1'b1;
    repeat (4) @(negedge CLK);
    VSYNC = 1'b0;
    repeat (6) @(negedge CLK);
    check_eq("f_gated_writes", wr_cnt - base, 0);
    check_eq("concurrent_lines", LINE_COUNT, 0);
    check_eq("concurrent_done", fd_cnt - fd0, 1);

    // Frame G: capture now enabled.
    base = wr_cnt;
    send_line(1, 8'hF8, 8'h1F);
    check_eq("g_writes", wr_cnt - base, 1);
    check_eq("g_addr0", log_addr[base], 0);

    // Reset in the middle of a line.
    HREF = 1'b1;
    for (int i = 0; i < 9; i++) begin
      CAM_DATA = i[0] ? 8'h1F : 8'hF8;
      @(negedge CLK);
    end
    check_eq("g_clip_before_rst", CLIP_ERR, 1);
    RESET = 1'b1;
    #1;
    check_eq("midrst_w_en", W_EN, 0);
    check_eq("midrst_w_addr", W_ADDR, 0);
    check_eq("midrst_lines", LINE_COUNT, 0);
    check_eq("midrst_clip", CLIP_ERR, 0);
    base = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      CAM_DATA = i[0] ? 8'h1F : 8'hF8;
      @(negedge CLK);
    end
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      CAM_DATA = i[0] ? 8'h1F : 8'hF8;
      @(negedge CLK);
    end
    HREF = 1'b0;
    repeat (6) @(negedge CLK);
    send_line(2, 8'hF8, 8'h1F);
    check_eq("postrst_writes", wr_cnt - base, 0);
    fd0 = fd_cnt;
    vsync_pulse(4);
    check_eq("postrst_no_done", fd_cnt - fd0, 0);
    base = wr_cnt;
    send_line(1, 8'hF8, 8'h1F);
    check_eq("postrst_first_addr", log_addr[base], 0);
    check_eq("postrst_first_data", log_data[base], 8'hE3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cam_capture_ds.md
Name: cam_capture_ds

Overview:
Camera capture front end for the OV7670 path.
- Samples VSYNC/HREF/CAM_DATA on the pixel clock and qualifies the sync edges with a filter.
- Assembles each two-byte pixel and converts it to RGB332 according to a run-time format select.
- Drives the write port of the dual-port M9K framebuffer with linear addresses computed incrementally.
- Replaces the ad-hoc capture logic in the top level; generalised in frame size, filter depth and pixel format, with frame gating and clip detection added.

Parameters:
SCREEN_WIDTH, 176, pixels per stored line
SCREEN_HEIGHT, 144, stored lines per frame
ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_WIDTH*SCREEN_HEIGHT
SYNC_FILT, 2, consecutive samples required to qualify a VSYNC rise or HREF fall (range 1..4)
LINE_W, 9, width of the line counter

Ports:
CLK  in  1  camera pixel clock (PCLK); all logic on posedge
RESET  in  1  asynchronous, active-high reset
VSYNC  in  1  camera frame sync, active high
HREF  in  1  camera line-valid
CAM_DATA  in  8  camera byte bus
FORMAT  in  2  0=RGB565, 1=RGB444 MSB-second, 2=RGB444 MSB-first, 3=grey (Y byte); sampled at frame start
CAPTURE_EN  in  1  frame-gated write enable; sampled at frame start
W_ADDR  out  ADDR_W  framebuffer write address
W_DATA  out  8  RGB332 pixel
W_EN  out  1  one-cycle write strobe
FRAME_DONE  out  1  one-cycle pulse at the end of a captured frame
LINE_COUNT  out  LINE_W  lines completed in the current frame
CLIP_ERR  out  1  sticky flag: a pixel fell outside the stored frame

Behaviour:
Sync filter:
- Shift histories of VSYNC and HREF, each SYNC_FILT+1 deep.
- vs_rise: last SYNC_FILT samples high and the oldest sample low.
- hr_fall: last SYNC_FILT samples low and the oldest sample high.

FSM states:
- WAIT_FRAME (reset state): ignore all data until vs_rise.
- ACTIVE: capture data.
- Transitions:
  - vs_rise in any state -> ACTIVE. Zero x, y and the address accumulator; set byte phase to 0; latch FORMAT and CAPTURE_EN into frame registers.
  - vs_rise in ACTIVE with LINE_COUNT != 0 -> FRAME_DONE=1 for one cycle.

In ACTIVE:
- HREF high, phase 0: store B0 = CAM_DATA; set phase to 1.
- HREF high, phase 1: form W = {CAM_DATA, B0}; convert; set phase to 0; advance x.
- hr_fall: increment y and LINE_COUNT; zero x and phase; set address base += SCREEN_WIDTH.
- HREF low with phase 1 (odd byte count): discard the partial byte; set phase to 0; no write.

Conversion (W = {B1, B0}):
- RGB565: {B0[7:5], B0[2:0], B1[4:3]}
- 444 MSB-second: {W[11:9], W[7:5], W[3:2]}
- 444 MSB-first: {W[3:1], W[15:13], W[11:10]}
- Grey: {B0[7:5], B0[7:5], B0[7:6]}

Address and write strobe:
- Address = base + x. No multiplier; base is an accumulator.
- Registered output: W_EN, W_ADDR and W_DATA are valid in the cycle after the second byte is sampled (latency 1).
- W_EN=1 only if the latched CAPTURE_EN=1, x < SCREEN_WIDTH and y < SCREEN_HEIGHT.
- A pixel with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT is suppressed and sets CLIP_ERR.

Boundary rules:
- CLIP_ERR clears only on RESET.
- LINE_COUNT saturates at 2^LINE_W-1.
- x saturates at SCREEN_WIDTH; no wrap into the next line.
- vs_rise and hr_fall in the same cycle: vs_rise wins; no line increment.
- Changes to CAPTURE_EN or FORMAT mid-frame have no effect until the next vs_rise.

Reset (including mid-frame):
- State = WAIT_FRAME.
- W_EN=0, W_ADDR=0, W_DATA=0, FRAME_DONE=0, LINE_COUNT=0, CLIP_ERR=0.
- Filter histories and frame registers cleared.
- No write occurs until a fresh vs_rise.

Optional Feature:
CAM_DECIM2_EN
- Defined: 2x decimation in both axes for CIF (352x288) input. Write only even pixels (camera column bit0=0) on even camera lines. x, y and the base accumulator advance only on kept pixels and lines. LINE_COUNT still counts camera lines.
- Undefined: every pixel is written; the decimation logic is absent.

Decomposition:
- Package cam_pkg: FORMAT encodings (FMT_RGB565, FMT_444_MSB2, FMT_444_MSB1, FMT_GREY), the FSM state encoding, and an RGB332 color localparam set (RED, GREEN, BLUE, WHITE).
- One sub-module, sync_edge_filt: instantiated twice, parameter SYNC_FILT, with a rising/falling select; outputs one qualified pulse.

Test Plan:
1. RESET, then one vs_rise. Two lines of 176 pixels in RGB565, first pixel bytes 0xF8, 0x1F. Required: W_DATA 0xE3 at W_ADDR 0; 352 W_EN pulses; last W_ADDR 351; LINE_COUNT=2; no CLIP_ERR.
2. FORMAT=1; bytes 0x5A, 0x0F (W=0x0F5A). Required: W_DATA = {W[11:9]=111, W[7:5]=010, W[3:2]=10} = 0xEA. FORMAT changed to 2 mid-frame: no effect until the next vs_rise.
3. Line of 180 pixels. Required: 176 writes; CLIP_ERR=1 persists through the next frame. 145th line produces no writes.
4. VSYNC glitch high for 1 cycle with SYNC_FILT=2: no frame restart. Sustained VSYNC after ACTIVE with 144 lines: FRAME_DONE single pulse; next frame's first write at W_ADDR 0.
5. HREF drops after 7 bytes: 3 writes; 7th byte discarded. Next line starts at W_ADDR = base+176. Concurrent vs_rise/hr_fall: LINE_COUNT reset to 0, not incremented.
6. CAPTURE_EN=0 at frame start, toggled to 1 mid-frame: zero writes that frame. RESET asserted mid-line: W_EN low immediately; no writes until the next vs_rise. With CAM_DECIM2_EN: 352x288 input gives 176x144 writes; last W_ADDR 25343.
